// File: rtl/uart_status_tx.sv
// rtl/uart_status_tx.sv - Serializes a snapshot of mode select and MM:SS time as an ASCII status frame
// Bytes are handed one at a time to a UART TX core over a start/done handshake.
module uart_status_tx #(
  parameter bit CRLF = 1'b1
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       send_i,
  input  logic [1:0] sel_i,
  input  logic [3:0] min_tens_i,
  input  logic [3:0] min_ones_i,
  input  logic [3:0] sec_tens_i,
  input  logic [3:0] sec_ones_i,
  input  logic       tx_done_i,
  output logic       tx_start_o,
  output logic [7:0] tx_data_o,
  output logic       busy_o,
  output logic       frame_done_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT
  } state_e;

  localparam logic [3:0] LAST_IDX = CRLF ? 4'd8 : 4'd6;

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [1:0]  sel_q, sel_d;
  logic [15:0] dig_q, dig_d;
  logic        frame_done_q, frame_done_d;
  logic [7:0]  frame_byte;

  // Non-BCD digit values are shown as '?' rather than wrapping into punctuation.
  function automatic logic [7:0] bcd_ascii(input logic [3:0] d);
    if (d <= 4'd9) begin
      return 8'h30 + {4'h0, d};
    end
    return 8'h3F;
  endfunction

  always_comb begin
    frame_byte = 8'h00;
    case (idx_q)
      4'd0:    frame_byte = 8'h30 + {6'b000000, sel_q};
      4'd1:    frame_byte = 8'h20;
      4'd2:    frame_byte = bcd_ascii(dig_q[15:12]);
      4'd3:    frame_byte = bcd_ascii(dig_q[11:8]);
      4'd4:    frame_byte = 8'h3A;
      4'd5:    frame_byte = bcd_ascii(dig_q[7:4]);
      4'd6:    frame_byte = bcd_ascii(dig_q[3:0]);
      4'd7:    frame_byte = 8'h0D;
      4'd8:    frame_byte = 8'h0A;
      default: frame_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    sel_d        = sel_q;
    dig_d        = dig_q;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (send_i) begin
          sel_d   = sel_i;
          dig_d   = {min_tens_i, min_ones_i, sec_tens_i, sec_ones_i};
          idx_d   = 4'd0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done_i) begin
          if (idx_q == LAST_IDX) begin
            idx_d        = 4'd0;
            frame_done_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_LOAD;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      idx_q        <= 4'd0;
      sel_q        <= 2'b00;
      dig_q        <= 16'h0000;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      sel_q        <= sel_d;
      dig_q        <= dig_d;
      frame_done_q <= frame_done_d;
    end
  end

  // tx_data is a mux of registered state only, so it stays stable through WAIT.
  assign tx_start_o   = (state_q == S_LOAD);
  assign busy_o       = (state_q != S_IDLE);
  assign tx_data_o    = busy_o ? frame_byte : 8'h00;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_uart_status_tx.sv
// tb/tb_uart_status_tx.sv - Directed table-driven bench for uart_status_tx (CRLF=1 and CRLF=0 instances)
module tb_uart_status_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       send_a, send_b, done_a, done_b;
  logic [1:0] sel;
  logic [3:0] mt, mo, st, so;
  logic       start_a, start_b, busy_a, busy_b, fd_a, fd_b;
  logic [7:0] data_a, data_b;

  uart_status_tx #(.CRLF(1'b1)) dut_a (
    .clk_i(clk), .reset_i(reset), .send_i(send_a), .sel_i(sel),
    .min_tens_i(mt), .min_ones_i(mo), .sec_tens_i(st), .sec_ones_i(so),
    .tx_done_i(done_a), .tx_start_o(start_a), .tx_data_o(data_a),
    .busy_o(busy_a), .frame_done_o(fd_a)
  );

  uart_status_tx #(.CRLF(1'b0)) dut_b (
    .clk_i(clk), .reset_i(reset), .send_i(send_b), .sel_i(sel),
    .min_tens_i(mt), .min_ones_i(mo), .sec_tens_i(st), .sec_ones_i(so),
    .tx_done_i(done_b), .tx_start_o(start_b), .tx_data_o(data_b),
    .busy_o(busy_b), .frame_done_o(fd_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_start_a = 0, cnt_start_b = 0, cnt_fd_a = 0, cnt_fd_b = 0;

  always @(negedge clk) begin
    if (start_a) cnt_start_a <= cnt_start_a + 1;
    if (start_b) cnt_start_b <= cnt_start_b + 1;
    if (fd_a)    cnt_fd_a    <= cnt_fd_a + 1;
    if (fd_b)    cnt_fd_b    <= cnt_fd_b + 1;
  end

  typedef struct packed {
    logic        use_b;
    logic        chain;
    logic [1:0]  sel;
    logic [15:0] dig;
    logic [15:0] dly;
    logic [3:0]  nbytes;
    logic [71:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic g_start(input logic b);
    return b ? start_b : start_a;
  endfunction
  function automatic logic [7:0] g_data(input logic b);
    return b ? data_b : data_a;
  endfunction
  function automatic logic g_busy(input logic b);
    return b ? busy_b : busy_a;
  endfunction
  function automatic logic g_fd(input logic b);
    return b ? fd_b : fd_a;
  endfunction
  function automatic int g_cs(input logic b);
    return b ? cnt_start_b : cnt_start_a;
  endfunction
  function automatic int g_cfd(input logic b);
    return b ? cnt_fd_b : cnt_fd_a;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    sel = v.sel;
    {mt, mo, st, so} = v.dig;
  endtask

  task automatic set_send(input logic b, input logic val);
    if (b) send_b = val; else send_a = val;
  endtask

  task automatic set_done(input logic b, input logic val);
    if (b) done_b = val; else done_a = val;
  endtask

  // Runs one frame with a TX model answering tx_done dly cycles after each tx_start.
  task automatic run_vec(input int id, input vec_t v, input bit sent_already, input vec_t nxt);
    logic       b;
    logic [7:0] d;
    bit         stable;
    int         cs0, cfd0;
    b    = v.use_b;
    cs0  = g_cs(b);
    cfd0 = g_cfd(b);
    if (!sent_already) begin
      apply(v);
      set_send(b, 1'b1);
      step();
      set_send(b, 1'b0);
    end
    sel = ~v.sel;
    {mt, mo, st, so} = (v.dig == 16'h1959) ? 16'h2500 : 16'h1959;
    for (int k = 0; k < int'(v.nbytes); k++) begin
      chk($sformatf("v%0d start%0d", id, k), g_start(b), 1);
      chk($sformatf("v%0d byte%0d", id, k), g_data(b), v.exp[71-8*k -: 8]);
      d = g_data(b);
      stable = 1'b1;
      for (int j = 0; j < int'(v.dly); j++) begin
        if (k == 2 && j == 0) set_send(b, 1'b1);
        step();
        set_send(b, 1'b0);
        if (g_start(b) || g_data(b) !== d || !g_busy(b)) stable = 1'b0;
      end
      chk($sformatf("v%0d hold%0d", id, k), stable, 1);
      set_done(b, 1'b1);
      step();
      set_done(b, 1'b0);
    end
    chk($sformatf("v%0d frame_done", id), g_fd(b), 1);
    chk($sformatf("v%0d busy_end", id), g_busy(b), 0);
    chk($sformatf("v%0d start_cnt", id), g_cs(b) - cs0, v.nbytes);
    if (v.chain) begin
      apply(nxt);
      set_send(b, 1'b1);
      step();
      set_send(b, 1'b0);
    end else begin
      step();
      chk($sformatf("v%0d fd_pulse", id), g_fd(b), 0);
      chk($sformatf("v%0d fd_cnt", id), g_cfd(b) - cfd0, 1);
      set_done(b, 1'b1);
      step();
      set_done(b, 1'b0);
      step();
      step();
      chk($sformatf("v%0d spurious_done", id), g_cs(b) - cs0, v.nbytes);
      chk($sformatf("v%0d idle_busy", id), g_busy(b), 0);
    end
  endtask

  initial begin
    vec_t rv;
    int   cs_r, cfd_r, nx;
    vecs[0] = '{1'b0, 1'b0, 2'd2, 16'h2500, 16'd3,    4'd9, 72'h32_20_32_35_3A_30_30_0D_0A};
    vecs[1] = '{1'b1, 1'b0, 2'd3, 16'hA3F9, 16'd3,    4'd7, 72'h33_20_3F_33_3A_3F_39_00_00};
    vecs[2] = '{1'b0, 1'b1, 2'd2, 16'h2500, 16'd1,    4'd9, 72'h32_20_32_35_3A_30_30_0D_0A};
    vecs[3] = '{1'b0, 1'b0, 2'd0, 16'h1959, 16'd2,    4'd9, 72'h30_20_31_39_3A_35_39_0D_0A};
    vecs[4] = '{1'b0, 1'b0, 2'd2, 16'h2500, 16'd1000, 4'd9, 72'h32_20_32_35_3A_30_30_0D_0A};
    vecs[5] = '{1'b1, 1'b0, 2'd0, 16'h0000, 16'd1,    4'd7, 72'h30_20_30_30_3A_30_30_00_00};

    reset = 1'b1;
    send_a = 1'b0; send_b = 1'b0; done_a = 1'b0; done_b = 1'b0;
    sel = 2'b00; mt = 4'h0; mo = 4'h0; st = 4'h0; so = 4'h0;
    step();
    step();
    chk("rst start_a", start_a, 0);
    chk("rst data_a", data_a, 8'h00);
    chk("rst busy_a", busy_a, 0);
    chk("rst fd_a", fd_a, 0);
    chk("rst start_b", start_b, 0);
    chk("rst busy_b", busy_b, 0);

    send_a = 1'b1;
    step();
    send_a = 1'b0;
    chk("rst_wins busy", busy_a, 0);
    chk("rst_wins start", start_a, 0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 6; i++) begin
      nx = (i < 5) ? i + 1 : i;
      run_vec(i, vecs[i], (i > 0) && vecs[i-1].chain, vecs[nx]);
    end

    // Reset mid-frame, with a tx_done coincident with tx_start along the way.
    sel = 2'd1;
    {mt, mo, st, so} = 16'h1234;
    send_a = 1'b1;
    step();
    send_a = 1'b0;
    chk("mid start0", start_a, 1);
    chk("mid byte0", data_a, 8'h31);
    done_a = 1'b1;
    step();
    done_a = 1'b0;
    chk("load_done start", start_a, 0);
    chk("load_done data", data_a, 8'h31);
    step();
    done_a = 1'b1;
    step();
    done_a = 1'b0;
    rv = '{1'b0, 1'b0, 2'd1, 16'h1234, 16'd2, 4'd9, 72'h31_20_31_32_3A_33_34_0D_0A};
    for (int k = 1; k < 4; k++) begin
      chk($sformatf("mid start%0d", k), start_a, 1);
      chk($sformatf("mid byte%0d", k), data_a, rv.exp[71-8*k -: 8]);
      step();
      step();
      done_a = 1'b1;
      step();
      done_a = 1'b0;
    end
    cfd_r = cnt_fd_a;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst start", start_a, 0);
    chk("mid_rst busy", busy_a, 0);
    chk("mid_rst data", data_a, 8'h00);
    chk("mid_rst fd", fd_a, 0);
    cs_r = cnt_start_a;
    step();
    step();
    step();
    chk("mid_rst no_start", cnt_start_a - cs_r, 0);
    chk("mid_rst no_fd", cnt_fd_a - cfd_r, 0);
    rv = '{1'b0, 1'b0, 2'd3, 16'h1234, 16'd2, 4'd9, 72'h33_20_31_32_3A_33_34_0D_0A};
    run_vec(9, rv, 1'b0, rv);

    chk("total fd_a", cnt_fd_a, 5);
    chk("total fd_b", cnt_fd_b, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_status_tx.md
Name: uart_status_tx

Overview:
- Transmit-side companion to the UART command decoder in the pomodoro timer.
- On request, snapshots the current mode select and remaining time (BCD MM:SS) and serializes them as an ASCII status frame, one byte at a time.
- Bytes are handed to the byte-level UART transmitter through a start/done handshake.
- Sits between the timer/display logic and the UART TX core.

Parameters:
- CRLF, 1, when 1 the frame ends with CR (8'h0D) and LF (8'h0A) for 9 bytes; when 0 the frame is 7 bytes with no terminator.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- send  input  1  frame request; sampled only in IDLE
- sel  input  2  current mode select (00..11)
- min_tens  input  4  BCD minutes tens digit
- min_ones  input  4  BCD minutes ones digit
- sec_tens  input  4  BCD seconds tens digit
- sec_ones  input  4  BCD seconds ones digit
- tx_done  input  1  one-cycle pulse from the UART TX core: byte fully shifted out
- tx_start  output  1  one-cycle pulse: tx_data valid, start transmitting
- tx_data  output  8  byte to transmit; held stable from tx_start until the matching tx_done
- busy  output  1  high while a frame is in progress
- frame_done  output  1  one-cycle pulse after the last byte's tx_done

Behaviour:
- Reset values: tx_start=0, tx_data=8'h00, busy=0, frame_done=0, state=IDLE, byte index=0.
- Reset is synchronous and active-high. It applies mid-frame as well: the block returns to IDLE the next edge, emits no further tx_start and no frame_done.
- Frame byte order:
  - idx0: 8'h30+sel
  - idx1: 8'h20 (space)
  - idx2: min_tens
  - idx3: min_ones
  - idx4: 8'h3A (':')
  - idx5: sec_tens
  - idx6: sec_ones
  - idx7: 8'h0D (CR, only if CRLF=1)
  - idx8: 8'h0A (LF, only if CRLF=1)
- Digit encoding: a BCD value 0..9 maps to 8'h30+value. A value of 10..15 maps to 8'h3F ('?').
- Snapshot: sel and all four digits are registered on the cycle send is accepted. Later input changes do not affect the frame in flight.
- States and transitions:
  - IDLE: send=1 at edge n captures the snapshot, sets busy=1 at n+1, goes to LOAD.
  - LOAD: drives tx_data with byte[idx] and pulses tx_start for exactly one cycle. The first tx_start is at cycle n+1, so latency is 1 cycle. Goes to WAIT.
  - WAIT: holds tx_data. When tx_done=1:
    - if idx < last, idx increments and the block goes to LOAD, so the next tx_start is 1 cycle after tx_done;
    - if idx = last, the block goes to IDLE with busy=0 and frame_done=1 for one cycle, both on the cycle after tx_done.
- Handshake rules:
  - tx_done is honoured only in WAIT. It is ignored in IDLE, and ignored in LOAD, i.e. on the same cycle as tx_start.
  - At most one tx_start per tx_done.
  - There is no timeout: WAIT holds indefinitely until tx_done arrives.
- Simultaneous events:
  - send while busy is ignored, with no queueing.
  - send on the same cycle frame_done pulses (state is IDLE) is accepted, giving back-to-back frames.
  - reset together with send or tx_done: reset wins.
- Width rule: the byte index counter is 4 bits, and last = 8 (CRLF=1) or 6 (CRLF=0).

Test Plan:
- Basic frame: reset, then sel=2'b10, digits 2,5,0,0, send pulse. The TX model answers tx_done 3 cycles after each tx_start. Required: tx_data sequence 32 20 32 35 3A 30 30 0D 0A, 9 tx_start pulses, frame_done exactly once, busy low the cycle after the 9th tx_done.
- Snapshot/latency: send at cycle n, then change digits to 1,9,5,9 at n+1. Required: tx_start at n+1, frame still carries the original 25:00 values, tx_data stable between each tx_start and its tx_done.
- Ignored requests: send pulses while busy, plus spurious tx_done pulses in IDLE. Required: no extra frames, no tx_start from the spurious tx_done; send coincident with frame_done starts a second frame immediately.
- Invalid BCD and CRLF=0: digits 4'hA, 3, 4'hF, 9 with sel=2'b11 and CRLF=0. Required: 33 20 3F 33 3A 3F 39, exactly 7 bytes, then frame_done.
- Reset mid-frame: assert reset after the 4th tx_done. Required: the next edge shows tx_start=0, busy=0, tx_data=00, and no frame_done; a subsequent send starts from idx0 ('0'+sel).
- Slow/fast transmitter: tx_done at 1 cycle and at 1000 cycles after tx_start. Required: identical byte sequences, and the next tx_start always exactly 1 cycle after each non-final tx_done.
